// File: rtl/rv32_pkg.sv
// Shared opcode, funct3/funct7 constants and ALU operation encoding for the RV32I integer core.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_e;

  // Operation selected by funct3 when funct7 (or imm[11:5]) is all zeros.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    case (funct3)
      F3_ADD_SUB: return ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SR:      return ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational 32-bit integer ALU; shifts use the low five bits of b.
module rv32_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << b[4:0];
      ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'd0, a < b};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/your_processor.sv
// Single-cycle RV32I integer-ALU core: decode, register file and writeback around rv32_alu.
module your_processor
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [31:0] data_out
);

  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        valid;
  alu_op_e     op;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_u  = {instruction[31:12], 12'h000};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  always_comb begin
    valid     = 1'b0;
    op        = ALU_ADD;
    operand_a = rs1_val;
    operand_b = rs2_val;
    case (opcode)
      OPC_OP: begin
        valid = 1'b1;
        if (funct7 == F7_BASE)
          op = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)
          op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == F3_SR)
          op = ALU_SRA;
        else
          valid = 1'b0;
      end
      OPC_OP_IMM: begin
        valid     = 1'b1;
        operand_b = imm_i;
        op        = base_op(funct3);
        // Only shift immediates constrain imm[11:5]; SRAI is the one alternate encoding.
        if (funct3 == F3_SLL)
          valid = (funct7 == F7_BASE);
        else if (funct3 == F3_SR) begin
          if (funct7 == F7_ALT)
            op = ALU_SRA;
          else if (funct7 != F7_BASE)
            valid = 1'b0;
        end
      end
      OPC_LUI: begin
        valid     = 1'b1;
        op        = ALU_PASS_B;
        operand_a = 32'd0;
        operand_b = imm_u;
      end
      default: valid = 1'b0;
    endcase
  end

  rv32_alu u_alu (
    .a      (operand_a),
    .b      (operand_b),
    .op     (op),
    .result (result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (valid) begin
      data_out <= result;
      if (rd != 5'd0)
        regs[rd] <= result;
    end
  end

endmodule

// File: tb/tb_your_processor.sv
// Directed bench for your_processor: expected writebacks queued on drive, popped and checked after each edge.
module tb_your_processor;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  your_processor dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic compare();
    logic [31:0] e;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (data_out === e) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", t, data_out, e);
      end
    end
  endtask

  task automatic expect_now(input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    compare();
  endtask

  task automatic exec(input logic [31:0] instr, input logic [31:0] e, input string t);
    @(negedge clk);
    instruction = instr;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 32'h00500093;
    #1;
    expect_now(32'h0, "reset_initial");
    repeat (2) @(posedge clk);
    #1;
    expect_now(32'h0, "reset_edges_ignored");
    @(negedge clk);
    reset = 1'b0;

    exec(32'h00000493, 32'h00000000, "addi_x9_after_reset");
    exec(32'h00500093, 32'h00000005, "addi_x1_5");
    exec(32'hFFD00113, 32'hFFFFFFFD, "addi_x2_m3");
    exec(32'h002081B3, 32'h00000002, "add");
    exec(32'h40208233, 32'h00000008, "sub");
    exec(32'h001122B3, 32'h00000001, "slt");
    exec(32'h00113333, 32'h00000000, "sltu");
    exec(32'h401153B3, 32'hFFFFFFFF, "sra");
    exec(32'h00409513, 32'h00000050, "slli");
    exec(32'h01C15593, 32'h0000000F, "srli");
    exec(32'h40115613, 32'hFFFFFFFE, "srai");
    exec(32'hFFF0C693, 32'hFFFFFFFA, "xori");
    exec(32'hFFF0B713, 32'h00000001, "sltiu");
    exec(32'hFFF0A793, 32'h00000000, "slti");
    exec(32'h0013D833, 32'h07FFFFFF, "srl");
    exec(32'h401098B3, 32'h07FFFFFF, "bad_funct7_nop");
    exec(32'h40409513, 32'h07FFFFFF, "bad_slli_imm_nop");
    exec(32'h00308A33, 32'h00000007, "add_x20_x1_x3");
    exec(32'h12345437, 32'h12345000, "lui");
    exec(32'h00700013, 32'h00000007, "addi_x0_data_out");
    exec(32'h000004B3, 32'h00000000, "x0_reads_zero");
    exec(32'h0083F933, 32'h12345000, "and");
    exec(32'hFFFFFFFF, 32'h12345000, "unsupported_hold");
    exec(32'h000404B3, 32'h12345000, "x8_unchanged");
    exec(32'h00008993, 32'h00000005, "x1_unchanged");

    #2;
    reset = 1'b1;
    #1;
    expect_now(32'h0, "async_reset_mid_cycle");
    @(posedge clk);
    #1;
    expect_now(32'h0, "reset_held_over_edge");
    @(negedge clk);
    reset = 1'b0;
    exec(32'h002081B3, 32'h00000000, "regs_cleared_add");
    exec(32'h00808993, 32'h00000008, "addi_after_reset");
    exec(32'h01398A33, 32'h00000010, "back_to_back_forward");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/your_processor.md
# your_processor

Single-cycle RV32I integer-ALU core with an externally supplied instruction stream. One instruction is executed per clock. Its result is written to the register file and exposed on `data_out`. The core has no PC, instruction memory or data memory: the bench or a surrounding fetch unit drives `instruction` directly. The datapath is a three-bus organisation: two register read buses (rs1, rs2) and one writeback bus (rd).

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- `clk` input 1 — single clock; all state updates on rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state.
- `instruction` input 32 — instruction to execute this cycle; must be stable before each rising edge.
- `data_out` output 32 — registered writeback value of the most recently executed supported instruction.

## Operation
- Supported opcodes; anything else is a NOP:
  - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI (0110111).
- Decode:
  - funct7 must be 0000000, except SUB/SRA, which require 0100000.
  - For SLLI/SRLI/SRAI, imm[11:5] must be 0000000 (0100000 for SRAI).
  - Any other funct7 combination is a NOP.
- Immediates:
  - I-type: sign-extended instr[31:20].
  - LUI: {instr[31:12], 12'h000}.
- Arithmetic:
  - Modulo 2^32; no overflow flags.
  - Shift amount is the low 5 bits of rs2 or of the immediate.
  - SRA/SRAI replicate bit 31.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Both produce 0 or 1.
- Register file:
  - 32×32, two combinational read ports, one synchronous write port.
  - x0 always reads 0; writes to x0 are discarded.
- On each rising edge with a supported instruction:
  - rd ← result (unless rd = 0).
  - `data_out` ← result, even when rd = 0.
- NOP/unsupported instruction: no register write; `data_out` holds its value.
- Reading a register written by the previous instruction returns the new value. No hazards exist, since writes complete at the edge.

## Timing
- Reset (asynchronous assert): all 32 registers and `data_out` go to 0 immediately and stay 0 while `reset` = 1. Edges during reset are ignored.
- Reset deassertion: the first rising edge after deassertion executes the `instruction` present at that edge.
- Latency:
  - Decode, read and ALU are combinational.
  - The result is visible on `data_out` and in the register file after the same rising edge that samples the instruction.
  - Exactly one instruction per cycle.
- Reset mid-stream: in-flight state is discarded. Registers return to 0, and execution restarts from the instruction present after deassertion.
- Bench convention: the clock has a 10 ns period, and `instruction` changes once per period away from the rising edge.

## Structure
- Shared package `rv32_pkg`: opcode constants (OP, OP_IMM, LUI), funct3 constants, and an ALU-operation enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
- Sub-module `rv32_alu`: purely combinational, with inputs a, b and op, and output result. It is natural to isolate and unit-test.
- The register file, decoder and immediate generator live in the top module.

## Test plan
- Reset: with `reset` = 1, `data_out` = 0. After release, ADDI x9,x0,0 (0x00000493) gives `data_out` = 0 (registers cleared).
- Immediates: 0x00500093 (ADDI x1,x0,5) → 0x00000005. Then 0xFFD00113 (ADDI x2,x0,-3) → 0xFFFFFFFD.
- R-type ALU with the above register state:
  - 0x002081B3 (ADD x3,x1,x2) → 0x00000002.
  - 0x40208233 (SUB x4,x1,x2) → 0x00000008.
  - 0x001122B3 (SLT x5,x2,x1) → 0x00000001.
  - 0x00113333 (SLTU x6,x2,x1) → 0x00000000.
  - 0x401153B3 (SRA x7,x2,x1) → 0xFFFFFFFF.
- LUI: 0x12345437 (LUI x8,0x12345) → 0x12345000.
- x0 protection: 0x00700013 (ADDI x0,x0,7) → `data_out` = 7. The following 0x000004B3 (ADD x9,x0,x0) → 0.
- Unsupported opcode: 0xFFFFFFFF after a result of 0x12345000 → `data_out` stays 0x12345000 and no register changes. Asserting `reset` mid-cycle then zeroes `data_out` without waiting for a clock edge.
